pipelined_adder: RTL and testbench

//   Parametrised, pipelined add/subtract unit; successor to the 4-bit combinational adder.

---
 rtl/adder_pkg.sv | 47 ++++
 rtl/adder_chunk_stage.sv | 66 ++++++
 rtl/pipelined_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_adder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types for pipelined_adder and its chunk stages.
// Holds build defaults, the per-stage control bundle and the saturation decoder.
package adder_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int CHUNKS_DEF = 2;

  // Slice width for a given configuration.
  function automatic int chunk_w(input int width, input int chunks);
    return width / chunks;
  endfunction

  // Control half of a stage register.
  // The wide halves (a_hi, beff_hi, sum_lo) travel as separate vectors.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_msb;
    logic beff_msb;
    logic sub;
    logic sat;
    logic sgn;
  } stage_t;

  typedef enum logic [2:0] {
    CLAMP_NONE,
    CLAMP_SMAX,
    CLAMP_SMIN,
    CLAMP_ONES,
    CLAMP_ZERO
  } clamp_e;

  // s.carry holds the raw carry out of the MSB once the last slice is done.
  function automatic clamp_e sat_clamp(input stage_t s, input logic ovf);
    clamp_e c;
    c = CLAMP_NONE;
    unique case (1'b1)
      s.sat & s.sgn & ovf & s.a_msb:          c = CLAMP_SMIN;
      s.sat & s.sgn & ovf & ~s.a_msb:         c = CLAMP_SMAX;
      s.sat & ~s.sgn & ~s.sub & s.carry:      c = CLAMP_ONES;
      s.sat & ~s.sgn & s.sub & ~s.carry:      c = CLAMP_ZERO;
      default:                                c = CLAMP_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// adder_chunk_stage: adds slice IDX and registers the whole beat.
// Ports: clock/reset, adv_i (global advance), *_i previous stage, *_o this stage.
module adder_chunk_stage
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW    = 8,
  parameter int IDX   = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adv_i,
  input  stage_t           ctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] beff_i,
  input  logic [WIDTH-1:0] sum_i,
  output stage_t           ctl_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] beff_o,
  output logic [WIDTH-1:0] sum_o
);

  localparam int LO = IDX * CW;

  logic [CW:0]      slice;
  stage_t           ctl_d;
  stage_t           ctl_q;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] beff_q;

  always_comb begin
    slice = {1'b0, a_i[LO +: CW]}
          + {1'b0, beff_i[LO +: CW]}
          + {{CW{1'b0}}, ctl_i.carry};
    sum_d = sum_i;
    sum_d[LO +: CW] = slice[CW-1:0];
    ctl_d = ctl_i;
    ctl_d.carry = slice[CW];
  end

  // Data only loads with a valid beat so outputs stay put across bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctl_q  <= '0;
      a_q    <= '0;
      beff_q <= '0;
      sum_q  <= '0;
    end else if (adv_i) begin
      ctl_q.valid <= ctl_i.valid;
      if (ctl_i.valid) begin
        ctl_q  <= ctl_d;
        a_q    <= a_i;
        beff_q <= beff_i;
        sum_q  <= sum_d;
      end
    end
  end

  assign ctl_o  = ctl_q;
  assign a_o    = a_q;
  assign beff_o = beff_q;
  assign sum_o  = sum_q;

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: CHUNKS-stage add/sub with carry, overflow and valid/ready.
// Ports: clock, reset, io_in_* operand beat, io_out_* result beat.
// Optional ADDER_SAT_EN adds io_in_sat/io_in_signed and result clamping.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CHUNKS = CHUNKS_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic             io_in_sub,
  input  logic             io_in_cin,
`ifdef ADDER_SAT_EN
  input  logic             io_in_sat,
  input  logic             io_in_signed,
`endif
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
  output logic             io_out_cout,
  output logic             io_out_ovf
);

  localparam int CW  = chunk_w(WIDTH, CHUNKS);
  localparam int MSB = WIDTH - 1;

  if (CHUNKS < 1 || CHUNKS > WIDTH || (WIDTH % CHUNKS) != 0) begin : g_bad_cfg
    $fatal(1, "pipelined_adder: WIDTH must be a multiple of CHUNKS");
  end

  logic                         adv;
  logic [WIDTH-1:0]             beff;
  stage_t                       ctl_0;
  stage_t [CHUNKS-1:0]          ctl_q;
  logic [CHUNKS-1:0][WIDTH-1:0] a_q;
  logic [CHUNKS-1:0][WIDTH-1:0] beff_q;
  logic [CHUNKS-1:0][WIDTH-1:0] sum_q;

  // Global stall: every stage moves unless a finished beat is blocked.
  assign adv         = io_out_ready | ~io_out_valid;
  assign io_in_ready = adv;

  assign beff = io_in_sub ? ~io_in_b : io_in_b;

  always_comb begin
    ctl_0          = '0;
    ctl_0.valid    = io_in_valid;
    ctl_0.carry    = io_in_cin ^ io_in_sub;
    ctl_0.a_msb    = io_in_a[MSB];
    ctl_0.beff_msb = beff[MSB];
    ctl_0.sub      = io_in_sub;
`ifdef ADDER_SAT_EN
    ctl_0.sat      = io_in_sat;
    ctl_0.sgn      = io_in_signed;
`endif
  end

  for (genvar k = 0; k < CHUNKS; k++) begin : g_stage
    stage_t           ctl_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] beff_in;
    logic [WIDTH-1:0] sum_in;

    if (k == 0) begin : g_first
      assign ctl_in  = ctl_0;
      assign a_in    = io_in_a;
      assign beff_in = beff;
      assign sum_in  = '0;
    end else begin : g_next
      assign ctl_in  = ctl_q[k-1];
      assign a_in    = a_q[k-1];
      assign beff_in = beff_q[k-1];
      assign sum_in  = sum_q[k-1];
    end

    adder_chunk_stage #(
      .WIDTH (WIDTH),
      .CW    (CW),
      .IDX   (k)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .adv_i  (adv),
      .ctl_i  (ctl_in),
      .a_i    (a_in),
      .beff_i (beff_in),
      .sum_i  (sum_in),
      .ctl_o  (ctl_q[k]),
      .a_o    (a_q[k]),
      .beff_o (beff_q[k]),
      .sum_o  (sum_q[k])
    );
  end

  stage_t           last;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  assign last = ctl_q[CHUNKS-1];
  assign raw  = sum_q[CHUNKS-1];
  assign ovf  = (last.a_msb == last.beff_msb) & (raw[MSB] != last.a_msb);

  assign io_out_valid = last.valid;
  assign io_out_cout  = last.carry;
  assign io_out_ovf   = ovf;

`ifdef ADDER_SAT_EN
  always_comb begin
    io_out_sum = raw;
    unique case (sat_clamp(last, ovf))
      CLAMP_SMAX: io_out_sum = {1'b0, {MSB{1'b1}}};
      CLAMP_SMIN: io_out_sum = {1'b1, {MSB{1'b0}}};
      CLAMP_ONES: io_out_sum = '1;
      CLAMP_ZERO: io_out_sum = '0;
      default:    io_out_sum = raw;
    endcase
  end
`else
  assign io_out_sum = raw;
`endif

  // Operand copies past their own slice are only needed by later stages.
  logic unused_w;
  assign unused_w = ^{a_q, beff_q, ctl_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed + random checks of pipelined_adder.
// Reference is integer arithmetic on the operands; sweeps CHUNKS 1/4/16.
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int NS = 3;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset;
  logic         in_valid, in_ready, sub, cin, sat, sgn;
  logic [W-1:0] a, b, sum;
  logic         out_valid, out_ready, cout, ovf;
  logic         sw_valid;
  logic         sw_ir [NS];
  logic         sw_ov [NS];
  logic         sw_co [NS];
  logic         sw_of [NS];
  logic [W-1:0] sw_sum [NS];

  int   checks, errors, acc;
  res_t exp_q [$];
  logic dir_en;
  res_t dir_res;
  logic held;
  res_t hold_v;

  pipelined_adder #(.WIDTH(W), .CHUNKS(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_a      (a),
    .io_in_b      (b),
    .io_in_sub    (sub),
    .io_in_cin    (cin),
`ifdef ADDER_SAT_EN
    .io_in_sat    (sat),
    .io_in_signed (sgn),
`endif
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_sum   (sum),
    .io_out_cout  (cout),
    .io_out_ovf   (ovf)
  );

  function automatic int swc(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 4 : 16);
  endfunction

  for (genvar g = 0; g < NS; g++) begin : g_sw
    pipelined_adder #(.WIDTH(W), .CHUNKS(swc(g))) u_sw (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (sw_valid),
      .io_in_ready  (sw_ir[g]),
      .io_in_a      (a),
      .io_in_b      (b),
      .io_in_sub    (sub),
      .io_in_cin    (cin),
`ifdef ADDER_SAT_EN
      .io_in_sat    (sat),
      .io_in_signed (sgn),
`endif
      .io_out_valid (sw_ov[g]),
      .io_out_ready (1'b1),
      .io_out_sum   (sw_sum[g]),
      .io_out_cout  (sw_co[g]),
      .io_out_ovf   (sw_of[g])
    );
  end

  // Integer reference: unsigned and signed results judged by range.
  function automatic res_t model(input logic [W-1:0] ma, mb,
                                 input logic ms, mc, msat, msgn);
    int   ua, ub, sa, sb, ci, u, s;
    res_t r;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    ci = mc ? 1 : 0;
    if (ms) begin
      u = ua - ub - ci;
      s = sa - sb - ci;
      r.cout = (u >= 0);
    end else begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      r.cout = (u >= 65536);
    end
    r.sum = u[W-1:0];
    r.ovf = (s > 32767) || (s < -32768);
    if (msat && msgn && r.ovf) r.sum = ma[W-1] ? 16'h8000 : 16'h7FFF;
    else if (msat && !msgn && !ms && r.cout) r.sum = 16'hFFFF;
    else if (msat && !msgn && ms && !r.cout) r.sum = 16'h0000;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at posedge+1 with inputs set; scores handshakes of this cycle.
  task automatic cycle();
    res_t e;
    #1;
    if (held) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, hold_v.sum);
      chk("hold_cout", cout, hold_v.cout);
      chk("hold_ovf", ovf, hold_v.ovf);
    end
    if (out_valid && out_ready) begin
      chk("no_dup", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
      end
    end
    held   = out_valid && !out_ready;
    hold_v = '{sum, cout, ovf};
    if (in_valid && in_ready) begin
      acc++;
      exp_q.push_back(dir_en ? dir_res : model(a, b, sub, cin, sat, sgn));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [W-1:0] ta, tb_, input logic ts, tc,
                      input logic tsat, tsgn);
    in_valid = 1'b1;
    a = ta; b = tb_; sub = ts; cin = tc; sat = tsat; sgn = tsgn;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [W-1:0] ta, tb_, input logic ts, tc,
                          input logic tsat, tsgn,
                          input logic [W-1:0] es, input logic ec, eo);
    dir_en  = 1'b1;
    dir_res = '{es, ec, eo};
    send(ta, tb_, ts, tc, tsat, tsgn);
    dir_en  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    repeat (3) cycle();
  endtask

  initial begin
    int   lat;
    int   n;
    res_t e;
    logic seen [NS];
    checks = 0; errors = 0; acc = 0;
    dir_en = 1'b0; dir_res = '0; held = 1'b0; hold_v = '0;
    reset = 1'b1; in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0; sat = 1'b0; sgn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    reset = 1'b0;
    cycle();
    chk("rst_in_ready", in_ready, 1);

    // Basic add and latency.
    send_exp(16'h1234, 16'h1111, 0, 0, 0, 0, 16'h2345, 0, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("t1_latency", lat, 2);
    drain();

    // Carry/borrow boundaries, streamed back to back.
    send_exp(16'h00FF, 16'h0001, 0, 0, 0, 0, 16'h0100, 0, 0);
    send_exp(16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 0);
    send_exp(16'h0000, 16'h0001, 1, 0, 0, 0, 16'hFFFF, 0, 0);
    send_exp(16'h0005, 16'h0003, 1, 1, 0, 0, 16'h0001, 1, 0);
    send_exp(16'h7FFF, 16'h0001, 0, 0, 0, 0, 16'h8000, 0, 1);
    send_exp(16'h8000, 16'h0001, 1, 0, 0, 0, 16'h7FFF, 1, 1);
`ifdef ADDER_SAT_EN
    send_exp(16'h7FFF, 16'h0001, 0, 0, 1, 1, 16'h7FFF, 0, 1);
    send_exp(16'h8000, 16'h0001, 1, 0, 1, 1, 16'h8000, 1, 1);
    send_exp(16'hFFF0, 16'h0020, 0, 0, 1, 0, 16'hFFFF, 1, 0);
`endif
    drain();

    // Random stream with random back-pressure.
    acc = 0;
    n   = 0;
    while (acc < 64 && n < 2000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = W'($urandom);
      b         = W'($urandom);
      sub       = 1'($urandom_range(0, 1));
      cin       = 1'($urandom_range(0, 1));
`ifdef ADDER_SAT_EN
      sat       = 1'($urandom_range(0, 1));
      sgn       = 1'($urandom_range(0, 1));
`endif
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    sat = 1'b0; sgn = 1'b0;
    chk("rand_accepted", acc, 64);
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 0, 0, 0, 0);
    send(16'h3333, 16'h4444, 0, 0, 0, 0);
    chk("inflight_valid", out_valid, 1);
    reset = 1'b1;
    cycle();
    exp_q.delete();
    held = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    repeat (4) begin
      cycle();
      chk("post_rst_idle", out_valid, 0);
    end
    send_exp(16'h0102, 16'h0304, 0, 0, 0, 0, 16'h0406, 0, 0);
    drain();

    // CHUNKS sweep: latency and carry ripple across every bit.
    for (int v = 0; v <= 16; v++) begin
      a = W'((32'd1 << v) - 32'd1);
      b = 16'h0001;
      sub = 1'b0; cin = 1'b0;
      e = model(a, b, 0, 0, 0, 0);
      for (int g = 0; g < NS; g++) seen[g] = 1'b0;
      sw_valid = 1'b1;
      @(posedge clock);
      #1;
      sw_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        for (int g = 0; g < NS; g++) begin
          if (!seen[g] && sw_ov[g]) begin
            seen[g] = 1'b1;
            chk($sformatf("sw%0d_latency", swc(g)), k, swc(g));
            chk($sformatf("sw%0d_sum", swc(g)), sw_sum[g], e.sum);
            chk($sformatf("sw%0d_cout", swc(g)), sw_co[g], e.cout);
            chk($sformatf("sw%0d_ovf", swc(g)), sw_of[g], e.ovf);
          end
        end
        @(posedge clock);
        #1;
      end
      for (int g = 0; g < NS; g++)
        chk($sformatf("sw%0d_seen", swc(g)), seen[g], 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
